// File: rtl/color_conv_scheduler_pkg.sv
// Shared definitions for the colour-conversion scheduler: pixel port type,
// tree row selects, FSM states and default tree latency.
package color_conv_scheduler_pkg;

  localparam int CC_DATA_W   = 10;
  localparam int CC_TREE_LAT = 3;

  typedef struct packed {
    logic [CC_DATA_W-1:0] data;
    logic                 valid;
    logic                 sop;
    logic                 eop;
  } dctPort_t;

  typedef enum logic [1:0] {
    ROW_Y  = 2'd0,
    ROW_CB = 2'd1,
    ROW_CR = 2'd2
  } row_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW0 = 2'd1,
    ROW1 = 2'd2,
    ROW2 = 2'd3
  } cc_state_e;

endpackage

// File: rtl/color_conv_scheduler_collect.sv
// Tracks issues through the external tree, applies the chroma offset and
// presents Y/Cb/Cr together once the Cr row has come back.
module conv_result_collect
  import color_conv_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = CC_DATA_W,
  parameter int TREE_LAT   = CC_TREE_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tag_vld,
  input  logic [1:0]            i_tag_sel,
  input  logic                  i_tag_sop,
  input  logic                  i_tag_eop,
  input  logic [DATA_WIDTH-1:0] i_tree_sum,
  output dctPort_t [2:0]        o_out
);

  logic [TREE_LAT-1:0]       r_tag_vld_p0;
  logic [TREE_LAT-1:0][1:0]  r_tag_sel_p0;
  logic [TREE_LAT-1:0]       r_tag_sop_p0;
  logic [TREE_LAT-1:0]       r_tag_eop_p0;

  logic [DATA_WIDTH-1:0]     r_y_p1, r_cb_p1, r_cr_p1;
  logic                      r_done_p1, r_done_sop_p1, r_done_eop_p1;

  logic                      w_ret_vld;
  logic [1:0]                w_ret_sel;

  // Chroma rows are centred on mid-scale; the sum wraps rather than clips.
  function automatic logic [DATA_WIDTH-1:0] chroma_offset(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] off;
    off = '0;
    off[DATA_WIDTH-1] = 1'b1;
    return s + off;
  endfunction

  assign w_ret_vld = r_tag_vld_p0[TREE_LAT-1];
  assign w_ret_sel = r_tag_sel_p0[TREE_LAT-1];

  // p0: tag valid bits shadow each issue for exactly TREE_LAT cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld_p0 <= '0;
    end else begin
      r_tag_vld_p0[0] <= i_tag_vld;
      for (int k = 1; k < TREE_LAT; k++) r_tag_vld_p0[k] <= r_tag_vld_p0[k-1];
    end
  end

  // p0: tag payload travels with the valid bits; qualified by them downstream
  always_ff @(posedge clk) begin
    r_tag_sel_p0[0] <= i_tag_sel;
    r_tag_sop_p0[0] <= i_tag_sop;
    r_tag_eop_p0[0] <= i_tag_eop;
    for (int k = 1; k < TREE_LAT; k++) begin
      r_tag_sel_p0[k] <= r_tag_sel_p0[k-1];
      r_tag_sop_p0[k] <= r_tag_sop_p0[k-1];
      r_tag_eop_p0[k] <= r_tag_eop_p0[k-1];
    end
  end

  // p1: capture each returning row; the Cr row completes the pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_p1        <= '0;
      r_cb_p1       <= '0;
      r_cr_p1       <= '0;
      r_done_p1     <= 1'b0;
      r_done_sop_p1 <= 1'b0;
      r_done_eop_p1 <= 1'b0;
    end else begin
      r_done_p1     <= w_ret_vld && (w_ret_sel == ROW_CR);
      r_done_sop_p1 <= r_tag_sop_p0[TREE_LAT-1];
      r_done_eop_p1 <= r_tag_eop_p0[TREE_LAT-1];
      if (w_ret_vld) begin
        case (w_ret_sel)
          ROW_Y:   r_y_p1  <= i_tree_sum;
          ROW_CB:  r_cb_p1 <= chroma_offset(i_tree_sum);
          ROW_CR:  r_cr_p1 <= chroma_offset(i_tree_sum);
          default: ;
        endcase
      end
    end
  end

  // p2: registered outputs; data holds between pixels, valid pulses once
  always_ff @(posedge clk) begin
    if (rst) begin
      o_out <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        o_out[k].valid <= r_done_p1;
        o_out[k].sop   <= r_done_p1 & r_done_sop_p1;
        o_out[k].eop   <= r_done_p1 & r_done_eop_p1;
      end
      if (r_done_p1) begin
        o_out[0].data <= CC_DATA_W'(r_y_p1);
        o_out[1].data <= CC_DATA_W'(r_cb_p1);
        o_out[2].data <= CC_DATA_W'(r_cr_p1);
      end
    end
  end

endmodule

// File: rtl/color_conv_scheduler.sv
// RGB->YCbCr scheduler: accepts one pixel every three cycles and issues its
// three conversion rows, one per cycle, to a shared external products-sum tree.
module color_conv_scheduler
  import color_conv_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = CC_DATA_W,
  parameter int TREE_LAT   = CC_TREE_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  dctPort_t [2:0]             in,
  output logic                       in_ready,
  output logic [2:0][DATA_WIDTH-1:0] tree_x,
  output logic [1:0]                 tree_sel,
  output logic                       tree_vld,
  input  logic [DATA_WIDTH-1:0]      tree_sum,
  output dctPort_t [2:0]             out
);

  cc_state_e                  r_state, w_next;
  logic [2:0][DATA_WIDTH-1:0] r_hold;
  logic                       r_hold_sop, r_hold_eop;
  logic                       w_all_vld, w_ready, w_accept, w_tree_vld;
  row_sel_e                   w_tree_sel;

  assign w_all_vld = in[0].valid & in[1].valid & in[2].valid;
  assign w_accept  = w_ready & w_all_vld;

  // Next state and tree issue controls; a new pixel is taken only in IDLE or ROW2
  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_tree_vld = 1'b0;
    w_tree_sel = ROW_Y;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (w_all_vld) w_next = ROW0;
      end
      ROW0: begin
        w_tree_vld = 1'b1;
        w_tree_sel = ROW_Y;
        w_next     = ROW1;
      end
      ROW1: begin
        w_tree_vld = 1'b1;
        w_tree_sel = ROW_CB;
        w_next     = ROW2;
      end
      ROW2: begin
        w_ready    = 1'b1;
        w_tree_vld = 1'b1;
        w_tree_sel = ROW_CR;
        w_next     = w_all_vld ? ROW0 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Hold register: overwritten at the end of the ROW2 issue cycle, so the
  // Cr row still sees the old pixel and the next pixel follows without a gap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      r_hold_sop <= 1'b0;
      r_hold_eop <= 1'b0;
    end else if (w_accept) begin
      for (int k = 0; k < 3; k++) r_hold[k] <= DATA_WIDTH'(in[k].data);
      r_hold_sop <= in[0].sop | in[1].sop | in[2].sop;
      r_hold_eop <= in[0].eop | in[1].eop | in[2].eop;
    end
  end

  assign in_ready = w_ready;
  assign tree_x   = r_hold;
  assign tree_vld = w_tree_vld;
  assign tree_sel = w_tree_sel;

  conv_result_collect #(
    .DATA_WIDTH (DATA_WIDTH),
    .TREE_LAT   (TREE_LAT)
  ) u_collect (
    .clk        (clk),
    .rst        (rst),
    .i_tag_vld  (w_tree_vld),
    .i_tag_sel  (w_tree_sel),
    .i_tag_sop  (r_hold_sop),
    .i_tag_eop  (r_hold_eop),
    .i_tree_sum (tree_sum),
    .o_out      (out)
  );

endmodule

// File: tb/tb_color_conv_scheduler.sv
// Bench for color_conv_scheduler: behavioural tree, pixel-level reference
// model compared every cycle, plus literal checks on directed cases.
module tb_color_conv_scheduler;
  import color_conv_scheduler_pkg::*;

  localparam int W  = 10;
  localparam int TL = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  dctPort_t [2:0]       din;
  logic                 in_ready;
  logic [2:0][W-1:0]    tree_x;
  logic [1:0]           tree_sel;
  logic                 tree_vld;
  logic [W-1:0]         tree_sum;
  dctPort_t [2:0]       out;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int           mode = 1;           // 1: fixed table per row, 0: data-dependent hash
  logic [W-1:0] tbl [0:3];

  color_conv_scheduler #(.DATA_WIDTH(W), .TREE_LAT(TL)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .in_ready (in_ready),
    .tree_x   (tree_x),
    .tree_sel (tree_sel),
    .tree_vld (tree_vld),
    .tree_sum (tree_sum),
    .out      (out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] tree_fn(input logic [W-1:0] r, g, b, input int sel);
    int s;
    if (mode == 1) return tbl[sel & 3];
    s = 3 * int'(r) + 5 * int'(g) + 7 * int'(b) + 97 * sel + 13;
    return W'(s);
  endfunction

  // Behavioural tree: result for an issue appears TL cycles later
  logic         tp_v [0:TL];
  logic [W-1:0] tp_d [0:TL];
  always @(negedge clk) begin
    for (int k = TL; k > 0; k--) begin
      tp_v[k] = tp_v[k-1];
      tp_d[k] = tp_d[k-1];
    end
    tp_v[0] = tree_vld;
    tp_d[0] = tree_fn(tree_x[2], tree_x[1], tree_x[0], int'(tree_sel));
    tree_sum = tp_v[TL] ? tp_d[TL] : W'($urandom);
  end

  // Reference model: a pixel owns the tree for 3 cycles after its accept edge
  // and emerges 4+TL edges after it.
  typedef struct {
    int           due;
    logic [W-1:0] y, cb, cr;
    logic         sop, eop;
  } exp_t;

  exp_t         mq[$];
  bit           armed = 0;
  bit           m_act = 0;
  int           m_last = 0;
  bit           m_ready = 0;
  bit           busy;
  logic [W-1:0] m_hold [0:2] = '{0, 0, 0};
  logic [W-1:0] m_out  [0:2] = '{0, 0, 0};
  logic         ev, es, ee;

  always @(negedge clk) begin
    if (armed) begin
      busy    = m_act && ((cyc - m_last) <= 2);
      m_ready = !busy || ((cyc - m_last) == 2);
      chk("in_ready", in_ready, m_ready);
      chk("tree_vld", tree_vld, busy);
      chk("tree_sel", tree_sel, busy ? (cyc - m_last) : 0);
      for (int k = 0; k < 3; k++) chk("tree_x", tree_x[k], m_hold[k]);
      ev = 0; es = 0; ee = 0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        exp_t e;
        e = mq.pop_front();
        ev = 1; es = e.sop; ee = e.eop;
        m_out[0] = e.y; m_out[1] = e.cb; m_out[2] = e.cr;
      end
      for (int k = 0; k < 3; k++) begin
        chk("out_valid", out[k].valid, ev);
        chk("out_sop", out[k].sop, es);
        chk("out_eop", out[k].eop, ee);
        chk("out_data", out[k].data, m_out[k]);
      end
    end
    if (rst) begin
      armed = 1; m_act = 0; mq.delete();
      m_hold = '{0, 0, 0};
      m_out  = '{0, 0, 0};
    end else if (armed && m_ready && din[0].valid && din[1].valid && din[2].valid) begin
      exp_t e;
      m_act  = 1;
      m_last = cyc + 1;
      m_hold[0] = din[0].data; m_hold[1] = din[1].data; m_hold[2] = din[2].data;
      e.due = cyc + 1 + 4 + TL;
      e.y   = tree_fn(din[2].data, din[1].data, din[0].data, 0);
      e.cb  = W'(int'(tree_fn(din[2].data, din[1].data, din[0].data, 1)) + (1 << (W - 1)));
      e.cr  = W'(int'(tree_fn(din[2].data, din[1].data, din[0].data, 2)) + (1 << (W - 1)));
      e.sop = din[0].sop | din[1].sop | din[2].sop;
      e.eop = din[0].eop | din[1].eop | din[2].eop;
      mq.push_back(e);
    end
  end

  function automatic dctPort_t mk(input logic [W-1:0] d, input logic v, s, e);
    dctPort_t p;
    p.data = d; p.valid = v; p.sop = s; p.eop = e;
    return p;
  endfunction

  task automatic drop();
    for (int k = 0; k < 3; k++) din[k] = mk(din[k].data, 1'b0, 1'b0, 1'b0);
  endtask

  // Present a pixel (R,G,B) and wait for its accept edge; valids stay high
  task automatic send_pixel(input logic [W-1:0] r, g, b, input logic [2:0] sop, eop,
                            output int acc);
    din[2] = mk(r, 1'b1, sop[2], eop[2]);
    din[1] = mk(g, 1'b1, sop[1], eop[1]);
    din[0] = mk(b, 1'b1, sop[0], eop[0]);
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(input string name, input logic [W-1:0] ey, ecb, ecr,
                          input logic es, ee, input int due);
    int got;
    got = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out[0].valid) begin got = cyc; break; end
    end
    chk({name, "_cycle"}, got, due);
    if (got >= 0) begin
      chk({name, "_y"}, out[0].data, ey);
      chk({name, "_cb"}, out[1].data, ecb);
      chk({name, "_cr"}, out[2].data, ecr);
      chk({name, "_sop"}, out[0].sop, es);
      chk({name, "_eop"}, out[0].eop, ee);
    end
  endtask

  initial begin
    int a0, a1, a2, t0, cnt;
    din = '0;
    tbl[0] = 100; tbl[1] = 200; tbl[2] = 300; tbl[3] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Single pixel, rows return 100/200/300
    send_pixel(10'd1, 10'd2, 10'd3, 3'b000, 3'b000, a0);
    drop();
    wait_out("single", 10'd100, 10'd712, 10'd812, 1'b0, 1'b0, a0 + 7);
    repeat (4) @(posedge clk); #1;

    // Chroma wrap: Cb 600 -> 88, Cr 1023 -> 511
    tbl[0] = 5; tbl[1] = 600; tbl[2] = 1023;
    send_pixel(10'd7, 10'd8, 10'd9, 3'b000, 3'b000, a0);
    drop();
    wait_out("wrap", 10'd5, 10'd88, 10'd511, 1'b0, 1'b0, a0 + 7);
    repeat (4) @(posedge clk); #1;

    // Three back-to-back pixels; sop on R of the first, eop on B of the third
    tbl[0] = 100; tbl[1] = 200; tbl[2] = 300;
    send_pixel(10'd11, 10'd12, 10'd13, 3'b100, 3'b000, a0);
    send_pixel(10'd21, 10'd22, 10'd23, 3'b000, 3'b000, a1);
    send_pixel(10'd31, 10'd32, 10'd33, 3'b000, 3'b001, a2);
    drop();
    chk("b2b_spacing1", a1 - a0, 3);
    chk("b2b_spacing2", a2 - a1, 3);
    wait_out("b2b0", 10'd100, 10'd712, 10'd812, 1'b1, 1'b0, a0 + 7);
    wait_out("b2b1", 10'd100, 10'd712, 10'd812, 1'b0, 1'b0, a0 + 10);
    wait_out("b2b2", 10'd100, 10'd712, 10'd812, 1'b0, 1'b1, a0 + 13);
    repeat (4) @(posedge clk); #1;

    // G valid low for 5 cycles: nothing accepted, nothing issued
    mode = 0;
    din[2] = mk(10'd300, 1'b1, 1'b0, 1'b0);
    din[1] = mk(10'd400, 1'b0, 1'b0, 1'b0);
    din[0] = mk(10'd500, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk); if (tree_vld) cnt++;
      @(posedge clk); #1;
    end
    chk("partial_no_issue", cnt, 0);
    t0 = cyc;
    send_pixel(10'd300, 10'd400, 10'd500, 3'b000, 3'b000, a0);
    drop();
    chk("partial_accept_edge", a0 - t0, 1);
    repeat (14) @(posedge clk); #1;

    // Reset during ROW1 discards the pixel
    send_pixel(10'd55, 10'd66, 10'd77, 3'b000, 3'b000, a0);
    drop();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    cnt = 0;
    repeat (12) begin @(negedge clk); if (out[0].valid) cnt++; end
    chk("no_out_after_rst", cnt, 0);
    @(posedge clk); #1;
    mode = 1;
    send_pixel(10'd1, 10'd1, 10'd1, 3'b010, 3'b010, a0);
    drop();
    wait_out("post_rst", 10'd100, 10'd712, 10'd812, 1'b1, 1'b1, a0 + 7);
    repeat (4) @(posedge clk); #1;

    // Random traffic with occasional reset, checked by the model every cycle
    mode = 0;
    repeat (400) begin
      for (int k = 0; k < 3; k++)
        din[k] = mk(W'($urandom), $urandom_range(0, 9) < 8,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    rst = 0;
    drop();
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/color_conv_scheduler.md
COLOR_CONV_SCHEDULER -- requirements
Module: color_conv_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 10: width of every pixel component and of every tree sum.
REQ-002 Parameter TREE_LAT, default 3: fixed cycles from tree_vld issue to tree_sum return.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in  input  dctPort_t[3]  R/G/B components (in[2]=R, in[1]=G, in[0]=B), each carrying data/valid/sop/eop.
REQ-006 in_ready  output  1  pixel accepted on an edge where in_ready=1 and all three in[k].valid=1.
REQ-007 tree_x  output  DATA_WIDTH x3  held R/G/B operands driven to the shared products-sum tree.
REQ-008 tree_sel  output  2  coefficient row for the tree: 0=Y, 1=Cb, 2=Cr.
REQ-009 tree_vld  output  1  an issue to the tree this cycle.
REQ-010 tree_sum  input  DATA_WIDTH  tree result, valid exactly TREE_LAT cycles after the matching issue.
REQ-011 out  output  dctPort_t[3]  out[0]=Y, out[1]=Cb, out[2]=Cr; valid/sop/eop identical on all three.

Function
REQ-012 The block SHALL time-multiplex one tree across the three conversion rows: one pixel per 3 cycles.
REQ-013 FSM states IDLE, ROW0, ROW1, ROW2; reset state IDLE.
REQ-014 in_ready SHALL be 1 in IDLE and ROW2, else 0.
REQ-015 Acceptance: operands latch into a hold register; sop = OR of in[k].sop, eop = OR of in[k].eop.
REQ-016 Acceptance with fewer than three valids asserted SHALL NOT occur; state is unchanged.
REQ-017 Transitions: IDLE→ROW0 on accept; ROW0→ROW1; ROW1→ROW2; ROW2→ROW0 on accept, else IDLE.
REQ-018 In ROWr, tree_vld=1, tree_sel=r and tree_x=hold register; in IDLE tree_vld=0, tree_sel=0, tree_x hold their last value.
REQ-019 In ROW2, accepting a new pixel overwrites the hold register only after that cycle's issue (back-to-back, no bubble).
REQ-020 A TREE_LAT-deep tag pipeline SHALL carry {vld, sel, sop, eop} alongside each issue.
REQ-021 Returned Y SHALL be stored unchanged.
REQ-022 Returned Cb/Cr SHALL be stored as tree_sum + 2^(DATA_WIDTH-1), truncated mod 2^DATA_WIDTH (wrap, no saturation).
REQ-023 When the sel=2 tag returns, the registered outputs SHALL update on the next edge with valid=1 for exactly one cycle.
REQ-024 Latency: accept on edge t gives out valid high during the cycle after edge t+4+TREE_LAT.
REQ-025 out sop/eop SHALL equal the sop/eop captured at that pixel's accept.
REQ-026 Output data SHALL hold its last value while valid=0.
REQ-027 No output backpressure; the consumer always accepts.

Reset
REQ-028 On rst=1 at an edge:
- FSM→IDLE; tag pipeline vld bits cleared.
- out[k].valid/sop/eop=0, out[k].data=0.
- hold register and tree_x=0; tree_vld=0, tree_sel=0.
REQ-029 Reset asserted mid-pixel discards that pixel; no out valid for it, including any still in flight in the tree.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-031 dctPort_t, the row-select enum (ROW_Y/ROW_CB/ROW_CR) and the default TREE_LAT constant belong in the shared coder package.
REQ-032 One sub-module, conv_result_collect, SHALL hold the tag pipeline, chroma offset and output registers; the FSM stays in the top.
REQ-033 The tree itself is external; the bench uses a behavioural tree model.

Verification
REQ-034 Single pixel, DATA_WIDTH=10, model returns 100/200/300 for sel 0/1/2 -> Y=100, Cb=712, Cr=812, valid one cycle at t+4+TREE_LAT.
REQ-035 Three back-to-back pixels, all valids held high:
- in_ready pattern 1,0,0,1,0,0,1.
- tree_sel sequence 0,1,2,0,1,2,0,1,2.
- Three outputs spaced 3 cycles apart.
REQ-036 Cb return of 600 -> Cb=88 (wrap); Cr return of 1023 -> Cr=511.
REQ-037 in[1].valid=0 with others high for 5 cycles -> no accept, tree_vld=0; raising it yields one accept next edge.
REQ-038 sop on in[2] only for first pixel, eop on in[0] only for third -> out sop on output 1 only, eop on output 3 only.
REQ-039 rst pulsed during ROW1 -> no out valid for that pixel; FSM IDLE, in_ready=1 next cycle; a following pixel converts correctly.
